// File: rtl/hilo_mdu.sv
// hilo_mdu: architectural HI/LO registers with MTHI/MTLO, MFHI/MFLO and a 32-iteration shift-add MULT/MULTU
module hilo_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [4:0]  alucontrol,
    input  logic        hilowrite,
    input  logic        hilosel,
    input  logic        ifhilo,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [4:0] ALUCONTROL_MULT  = 5'b10000;
    localparam logic [4:0] ALUCONTROL_MULTU = 5'b10001;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        neg;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        is_mul;
    logic        is_signed;
    logic        start;
    logic        mt;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] prod;
    always_comb begin
        is_mul     = alucontrol == ALUCONTROL_MULT || alucontrol == ALUCONTROL_MULTU;
        is_signed  = alucontrol == ALUCONTROL_MULT;
        start      = valid & hilowrite & is_mul & !flush & (state == IDLE);
        mt         = valid & hilowrite & !is_mul & !flush & (state == IDLE);
        stall      = start | ((state == MUL) & !flush);
        abs_a      = (is_signed & srca[31]) ? -srca : srca;
        abs_b      = (is_signed & srcb[31]) ? -srcb : srcb;
        prod       = neg ? -acc : acc;
        hilo_rdata = (valid & ifhilo) ? (hilosel ? hi : lo) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state  <= MUL;
                cnt    <= '0;
                neg    <= is_signed & (srca[31] ^ srcb[31]);
                acc    <= '0;
                mcand  <= {32'd0, abs_a};
                mplier <= abs_b;
            end else if (mt) begin
                if (hilosel) hi <= srca;
                else lo <= srca;
            end
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) state <= DONE;
        end else begin
            // DONE: the multiply instruction is still in EX, so only write back and return to IDLE
            {hi, lo} <= prod;
            state    <= IDLE;
            cnt      <= '0;
        end
    end
endmodule
